tdc_pulse_gen: RTL and testbench

Programmable START/STOP stimulus generator that drives the TDC measurement interface from the opposite end. It emits arm, START and STOP edges with an exactly programmed coarse interval, pulse width, repetition count and inter-burst gap. It is used for loopback self-test and calibration of the TDC core on the same 200 MHz clock. It can also drive the board output pins for external characterisation.

---
 rtl/tdc_pkg.sv | 17 +
 rtl/tdc_pulse_stretch.sv | 30 +++
 rtl/tdc_pulse_gen.sv | 151 +++++++++++++++
 tb/tb_tdc_pulse_gen.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared constants and state encoding for the TDC stimulus generator.
package tdc_pkg;

  localparam int TDC_CNT_W     = 29;
  localparam int TDC_MIN_GAP   = 2;
  localparam int TDC_SETUP_LEN = 1;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SETUP,
    RUN,
    TAIL,
    GAP
  } state_t;

endpackage

// File: rtl/tdc_pulse_stretch.sv
// Registered pulse of programmable width, restarted by load.
module tdc_pulse_stretch #(
  parameter int PW_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            load,
  input  logic [PW_W-1:0] width,
  output logic            q
);

  logic [PW_W-1:0] cnt;

  // width is clamped to >= 1 by the caller
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q   <= 1'b0;
      cnt <= '0;
    end else if (load) begin
      q   <= 1'b1;
      cnt <= width - 1'b1;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end else begin
      q <= 1'b0;
    end
  end

endmodule

// File: rtl/tdc_pulse_gen.sv
// Programmable arm/START/STOP burst generator for TDC loopback and calibration.
module tdc_pulse_gen
  import tdc_pkg::*;
#(
  parameter int CNT_W = TDC_CNT_W,
  parameter int PW_W  = 8,
  parameter int REP_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cfg_interval,
  input  logic [PW_W-1:0]  cfg_width,
  input  logic [REP_W-1:0] cfg_count,
  input  logic [REP_W-1:0] cfg_gap,
  input  logic             go,
  input  logic             abort,
  output logic             arm_out,
  output logic             start_out,
  output logic             stop_out,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] rep_idx
);

  state_t           state, nxt;
  logic             pend;
  logic [CNT_W-1:0] ctr, ctr_nxt;
  logic [CNT_W-1:0] n_eff;
  logic [PW_W-1:0]  w_eff;
  logic [REP_W-1:0] cnt_cfg, gap_eff;
  logic             start_ld, stop_ld, fin, last;
  logic             accept;

  assign last   = (cnt_cfg != '0) && (rep_idx == cnt_cfg - 1'b1);
  assign accept = (state == IDLE) && !pend && go && !abort;

  always_comb begin
    nxt      = state;
    ctr_nxt  = ctr;
    start_ld = 1'b0;
    stop_ld  = 1'b0;
    fin      = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend) nxt = ARM;
      end
      ARM: begin
        nxt     = SETUP;
        ctr_nxt = CNT_W'(TDC_SETUP_LEN - 1);
      end
      SETUP: begin
        if (ctr == '0) begin
          nxt      = RUN;
          ctr_nxt  = n_eff - 1'b1;
          start_ld = 1'b1;
        end else begin
          ctr_nxt = ctr - 1'b1;
        end
      end
      RUN: begin
        if (ctr == '0) begin
          nxt     = TAIL;
          ctr_nxt = CNT_W'(w_eff) - 1'b1;
          stop_ld = 1'b1;
        end else begin
          ctr_nxt = ctr - 1'b1;
        end
      end
      TAIL: begin
        if (ctr == '0) begin
          if (last) begin
            nxt = IDLE;
            fin = 1'b1;
          end else begin
            nxt     = GAP;
            ctr_nxt = CNT_W'(gap_eff) - 1'b1;
          end
        end else begin
          ctr_nxt = ctr - 1'b1;
        end
      end
      GAP: begin
        if (ctr == '0) nxt = ARM;
        else ctr_nxt = ctr - 1'b1;
      end
      default: nxt = IDLE;
    endcase
    // abort overrides every transition and load
    if (abort) begin
      nxt      = IDLE;
      start_ld = 1'b0;
      stop_ld  = 1'b0;
      fin      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pend    <= 1'b0;
      ctr     <= '0;
      n_eff   <= '0;
      w_eff   <= '0;
      cnt_cfg <= '0;
      gap_eff <= '0;
      rep_idx <= '0;
      arm_out <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= nxt;
      ctr     <= ctr_nxt;
      pend    <= accept;
      arm_out <= (nxt == ARM);
      busy    <= (nxt != IDLE);
      done    <= fin;
      if (accept) begin
        n_eff   <= (cfg_interval == '0) ? CNT_W'(1) : cfg_interval;
        w_eff   <= (cfg_width == '0) ? PW_W'(1) : cfg_width;
        cnt_cfg <= cfg_count;
        gap_eff <= (cfg_gap < REP_W'(TDC_MIN_GAP)) ?
                   REP_W'(TDC_MIN_GAP) : cfg_gap;
      end
      if (!abort) begin
        if (state == IDLE && pend)
          rep_idx <= '0;
        else if (state == GAP && ctr == '0)
          rep_idx <= rep_idx + 1'b1;
      end
    end
  end

  tdc_pulse_stretch #(.PW_W(PW_W)) u_start (
    .clk   (clk),
    .rst   (rst),
    .clr   (abort),
    .load  (start_ld),
    .width (w_eff),
    .q     (start_out)
  );

  tdc_pulse_stretch #(.PW_W(PW_W)) u_stop (
    .clk   (clk),
    .rst   (rst),
    .clr   (abort),
    .load  (stop_ld),
    .width (w_eff),
    .q     (stop_out)
  );

endmodule

// File: tb/tb_tdc_pulse_gen.sv
// Scoreboard bench: per-cycle expected outputs derived from the burst timeline.
module tb_tdc_pulse_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [28:0] cfg_interval;
  logic [7:0]  cfg_width;
  logic [15:0] cfg_count;
  logic [15:0] cfg_gap;
  logic        go;
  logic        abort;
  logic        arm_out, start_out, stop_out, busy, done;
  logic [15:0] rep_idx;

  int errors = 0;
  int checks = 0;
  logic [20:0] sb[$];
  logic [15:0] prev_rep = 16'd0;

  always #5 clk = ~clk;

  tdc_pulse_gen dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_interval (cfg_interval),
    .cfg_width    (cfg_width),
    .cfg_count    (cfg_count),
    .cfg_gap      (cfg_gap),
    .go           (go),
    .abort        (abort),
    .arm_out      (arm_out),
    .start_out    (start_out),
    .stop_out     (stop_out),
    .busy         (busy),
    .done         (done),
    .rep_idx      (rep_idx)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {arm,start,stop,busy,done,rep} at cycle k of an unaborted burst
  function automatic logic [20:0] expv(input int k, input int n,
                                       input int w, input int cnt,
                                       input int p);
    int r, o;
    int dc;
    r  = (k - 1) / p;
    o  = (k - 1) % p;
    dc = 1 + (cnt - 1) * p + 2 + n + w;
    if (cnt != 0 && (r > cnt - 1 || (r == cnt - 1 && o >= 2 + n + w)))
      return {4'b0000, (k == dc), 16'(cnt - 1)};
    return {(o == 0), (o >= 2 && o < 2 + w),
            (o >= 2 + n && o < 2 + n + w), 1'b1, 1'b0, 16'(r)};
  endfunction

  task automatic run(input int n, input int w, input int cnt,
                     input int gap, input int end_at, input bit use_rst,
                     input int extra, input bit poke);
    int ne, we, ge, p, total, k_rise;
    logic [20:0] e, got;
    logic [15:0] hold;
    logic        ps, pp;
    ne = (n == 0) ? 1 : n;
    we = (w == 0) ? 1 : w;
    ge = (gap < 2) ? 2 : gap;
    p  = 2 + ne + we + ge;
    if (end_at > 0) total = end_at + extra;
    else total = 1 + (cnt - 1) * p + 2 + ne + we + extra;
    hold = 16'd0;
    if (end_at > 0 && !use_rst) begin
      e = expv(end_at, ne, we, cnt, p);
      hold = e[15:0];
    end
    sb.push_back({5'b00000, prev_rep});
    for (int k = 1; k <= total; k++) begin
      if (end_at > 0 && k > end_at) e = {5'b00000, hold};
      else e = expv(k, ne, we, cnt, p);
      sb.push_back(e);
    end
    cfg_interval = 29'(n);
    cfg_width    = 8'(w);
    cfg_count    = 16'(cnt);
    cfg_gap      = 16'(gap);
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    ps = 1'b0;
    pp = 1'b0;
    k_rise = -1;
    for (int k = 0; k <= total; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      got = {arm_out, start_out, stop_out, busy, done, rep_idx};
      if (sb.size() == 0) begin
        chk("sb_empty", 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        chk($sformatf("n%0d_w%0d_c%0d_k%0d", n, w, cnt, k),
            32'(got), 32'(e));
        prev_rep = e[15:0];
      end
      if (start_out && !ps) k_rise = k;
      if (stop_out && !pp && k_rise >= 0)
        chk($sformatf("interval_k%0d", k), 32'(k - k_rise), 32'(ne));
      ps = start_out;
      pp = stop_out;
      if (poke && k == 3) begin
        go = 1'b1;
        cfg_interval = 29'd5;
        cfg_width = 8'd1;
      end
      if (poke && k == 4) go = 1'b0;
      if (end_at > 0 && k == end_at) begin
        if (use_rst) rst = 1'b1;
        else abort = 1'b1;
      end
      if (end_at > 0 && k == end_at + 1) begin
        rst = 1'b0;
        abort = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    go = 1'b0;
    abort = 1'b0;
    cfg_interval = '0;
    cfg_width = '0;
    cfg_count = '0;
    cfg_gap = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", 32'({arm_out, start_out, stop_out, busy, done, rep_idx}),
        32'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    run(10, 3, 1, 0, 0, 1'b0, 3, 1'b0);
    run(0, 0, 1, 0, 0, 1'b0, 2, 1'b0);
    run(2, 5, 1, 0, 0, 1'b0, 2, 1'b0);
    run(10, 3, 3, 4, 0, 1'b0, 3, 1'b1);
    run(10, 3, 1, 0, 8, 1'b0, 4, 1'b0);
    run(10, 3, 3, 4, 17, 1'b1, 4, 1'b0);
    prev_rep = 16'd0;
    run(37, 4, 2, 0, 0, 1'b0, 2, 1'b0);
    run(1, 1, 0, 2, 17, 1'b0, 3, 1'b0);
    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
